dmux_rr_dispatcher: RTL and testbench

- Sequencing controller around the 1-to-N demultiplexer.
- Accepts one stream of words over a valid/ready handshake.
- Holds each word in a single output register and steers it to one of NOUT output channels.
- Channel select advances round-robin after every BURST accepted transfers, so one upstream producer can be shared between several consumers (e.g. ALU result to register/memory sinks).

---
 rtl/dmux_rr_dispatcher.sv | 126 ++++++++++++
 tb/tb_dmux_rr_dispatcher.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_rr_dispatcher.sv
// dmux_rr_dispatcher: single-register 1-to-NOUT dispatcher with round-robin channel
// select that advances after every BURST completed transfers.
// Optional macro DMUX_STALL_SKIP_EN: a held word whose channel stays not-ready for
// STALL_MAX consecutive cycles is retargeted to the next channel.
module dmux_rr_dispatcher #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NOUT      = 2,
    parameter int unsigned BURST     = 4,
    parameter int unsigned STALL_MAX = 8,
    localparam int unsigned SEL_W    = (NOUT > 2) ? $clog2(NOUT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [NOUT-1:0]  out_valid,
    input  logic [NOUT-1:0]  out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [3:0]       burst_cnt
);

    // Elaboration-time legality checks on the configuration.
    if (NOUT < 2 || NOUT > 8) begin : g_bad_nout
        $error("NOUT must be in 2..8");
    end
    if (BURST < 1 || BURST > 15) begin : g_bad_burst
        $error("BURST must be in 1..15");
    end
    if (STALL_MAX < 1 || STALL_MAX > 255) begin : g_bad_stall
        $error("STALL_MAX must be in 1..255");
    end

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [3:0]       burst_q, burst_d;

    logic             ready_sel;
    logic             accept;
    logic             xfer;
    logic [SEL_W-1:0] sel_inc;

`ifdef DMUX_STALL_SKIP_EN
    logic [7:0]       stall_q, stall_d;
`endif

    // State register and datapath flops; reset discards any held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sel_q   <= '0;
            burst_q <= '0;
`ifdef DMUX_STALL_SKIP_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            burst_q <= burst_d;
`ifdef DMUX_STALL_SKIP_EN
            stall_q <= stall_d;
`endif
        end
    end

    // Next-state logic: a transfer with a simultaneous accept keeps the register full.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (xfer && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Outputs and handshake decode; in_ready is the only input-to-output path.
    always_comb begin
        ready_sel = out_ready[sel_q];
        in_ready  = (state_q == StEmpty) || ready_sel;
        accept    = in_valid && in_ready;
        xfer      = (state_q == StFull) && ready_sel;
        out_valid = '0;
        if (state_q == StFull) begin
            out_valid[sel_q] = 1'b1;
        end
        out_data  = data_q;
        sel       = sel_q;
        burst_cnt = burst_q;
    end

    // Datapath next-state: capture on accept, advance burst/select on transfer.
    always_comb begin
        sel_inc = (sel_q == SEL_W'(NOUT - 1)) ? '0 : sel_q + 1'b1;
        data_d  = accept ? in_data : data_q;
        sel_d   = sel_q;
        burst_d = burst_q;
        if (xfer) begin
            if (burst_q == 4'(BURST - 1)) begin
                burst_d = '0;
                sel_d   = sel_inc;
            end else begin
                burst_d = burst_q + 4'd1;
            end
        end
`ifdef DMUX_STALL_SKIP_EN
        stall_d = stall_q;
        if (state_q != StFull || xfer) begin
            stall_d = '0;
        end else if (stall_q == 8'(STALL_MAX - 1)) begin
            // Last tolerated stall cycle: hand the held word to the next channel.
            stall_d = '0;
            sel_d   = sel_inc;
            burst_d = '0;
        end else begin
            stall_d = stall_q + 8'd1;
        end
`endif
    end

endmodule

// File: tb/tb_dmux_rr_dispatcher.sv
// Bench for dmux_rr_dispatcher: instance A (NOUT=2, BURST=4) and instance B
// (NOUT=3, BURST=1) checked every cycle against a transfer-count model, plus
// directed scenarios with literal expectations.
module tb_dmux_rr_dispatcher;

`ifdef DMUX_STALL_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int STALL = 8;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] a_in_data;
    logic        a_in_valid, a_in_ready;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_valid, a_out_ready;
    logic [0:0]  a_sel;
    logic [3:0]  a_burst;

    logic [15:0] b_in_data;
    logic        b_in_valid, b_in_ready;
    logic [15:0] b_out_data;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [1:0]  b_sel;
    logic [3:0]  b_burst;

    dmux_rr_dispatcher #(.WIDTH(16), .NOUT(2), .BURST(4), .STALL_MAX(STALL)) u_dut_a (
        .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .sel(a_sel), .burst_cnt(a_burst)
    );

    dmux_rr_dispatcher #(.WIDTH(16), .NOUT(3), .BURST(1), .STALL_MAX(STALL)) u_dut_b (
        .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sel(b_sel), .burst_cnt(b_burst)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    // Model: destination follows from the number of transfers since the last
    // reset/retarget, counted from a base channel.
    int m_held[2], m_word[2], m_xfers[2], m_base[2], m_stall[2];

    int log_a_data[$], log_a_ch[$], log_a_cyc[$];
    int log_b_data[$], log_b_ch[$], log_b_cyc[$];

    function automatic int nout_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int burst_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int dest(input int i);
        return (m_base[i] + m_xfers[i] / burst_of(i)) % nout_of(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit rst, input bit iv, input logic [15:0] id,
                              input logic [7:0] ordy);
        int  d;
        bit  rdy, inr, acc, xf;
        if (rst) begin
            m_held[i] = 0; m_word[i] = 0; m_xfers[i] = 0; m_base[i] = 0; m_stall[i] = 0;
            return;
        end
        d   = dest(i);
        rdy = ordy[d];
        inr = (m_held[i] == 0) || rdy;
        acc = iv && inr;
        xf  = (m_held[i] != 0) && rdy;
        if (m_held[i] == 0 || xf) begin
            m_stall[i] = 0;
            if (xf) m_xfers[i]++;
        end else if (SKIP) begin
            m_stall[i]++;
            if (m_stall[i] == STALL) begin
                m_base[i]  = (d + 1) % nout_of(i);
                m_xfers[i] = 0;
                m_stall[i] = 0;
            end
        end
        if (acc) begin
            m_word[i] = int'(id);
            m_held[i] = 1;
        end else if (xf) begin
            m_held[i] = 0;
        end
    endtask

    task automatic cmp(input int i, input logic ir, input logic [7:0] ov, input logic [15:0] od,
                       input logic [7:0] sl, input logic [3:0] bc, input logic [7:0] ordy);
        int d;
        d = dest(i);
        chk($sformatf("m%0d_in_ready", i), 32'(ir), 32'((m_held[i] == 0) || ordy[d]));
        chk($sformatf("m%0d_out_valid", i), 32'(ov), (m_held[i] != 0) ? (32'd1 << d) : 32'd0);
        chk($sformatf("m%0d_out_data", i), 32'(od), 32'(m_word[i]));
        chk($sformatf("m%0d_sel", i), 32'(sl), 32'(d));
        chk($sformatf("m%0d_burst_cnt", i), 32'(bc), 32'(m_xfers[i] % burst_of(i)));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_held[i] = 0; m_word[i] = 0; m_xfers[i] = 0; m_base[i] = 0; m_stall[i] = 0;
        end
    end

    // Model advances on the same edge as the DUT, from the same stable inputs.
    always @(posedge clk) begin
        cyc++;
        model_step(0, reset, a_in_valid, a_in_data, 8'(a_out_ready));
        model_step(1, reset, b_in_valid, b_in_data, 8'(b_out_ready));
    end

    // Per-cycle comparison and transfer logging, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, a_in_ready, 8'(a_out_valid), a_out_data, 8'(a_sel), a_burst, 8'(a_out_ready));
            cmp(1, b_in_ready, 8'(b_out_valid), b_out_data, 8'(b_sel), b_burst, 8'(b_out_ready));
            for (int k = 0; k < 2; k++) begin
                if (!reset && a_out_valid[k] && a_out_ready[k]) begin
                    log_a_data.push_back(int'(a_out_data));
                    log_a_ch.push_back(k);
                    log_a_cyc.push_back(cyc);
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (!reset && b_out_valid[k] && b_out_ready[k]) begin
                    log_b_data.push_back(int'(b_out_data));
                    log_b_ch.push_back(k);
                    log_b_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_in_data = '0; a_in_valid = 1'b1; a_out_ready = 2'b11;
        b_in_data = '0; b_in_valid = 1'b1; b_out_ready = 3'b111;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;

        // Reset state
        chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_sel", 32'(a_sel), 32'd0);
        chk("rst_a_burst", 32'(a_burst), 32'd0);
        chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);

        // Streaming round-robin on A
        log_a_data.delete(); log_a_ch.delete(); log_a_cyc.delete();
        a_in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            a_in_data = 16'(k);
            tick();
        end
        a_in_valid = 1'b0;
        tick();
        chk("stream_count", 32'(log_a_data.size()), 32'd8);
        if (log_a_data.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("stream_data%0d", k), 32'(log_a_data[k]), 32'(k + 1));
                chk($sformatf("stream_ch%0d", k), 32'(log_a_ch[k]), (k < 4) ? 32'd0 : 32'd1);
                chk($sformatf("stream_cyc%0d", k), 32'(log_a_cyc[k] - log_a_cyc[0]), 32'(k));
            end
        end
        chk("stream_sel_end", 32'(a_sel), 32'd0);
        chk("stream_burst_end", 32'(a_burst), 32'd0);

        // Backpressure on A channel 0
        a_out_ready = 2'b10;
        a_in_data = 16'hA5A5; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 32'(a_out_valid), 32'h1);
            chk("bp_out_data", 32'(a_out_data), 32'hA5A5);
            chk("bp_in_ready", 32'(a_in_ready), 32'd0);
            chk("bp_sel", 32'(a_sel), 32'd0);
            tick();
        end
        a_out_ready = 2'b11;
        tick();
        chk("bp_burst_after", 32'(a_burst), 32'd1);
        chk("bp_valid_after", 32'(a_out_valid), 32'd0);

        // Burst-boundary overlap on B
        log_b_data.delete(); log_b_ch.delete(); log_b_cyc.delete();
        b_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_in_data = 16'(16'h10 + k);
            tick();
        end
        b_in_valid = 1'b0;
        tick();
        chk("ovl_count", 32'(log_b_data.size()), 32'd4);
        if (log_b_data.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("ovl_data%0d", k), 32'(log_b_data[k]), 32'(16'h10 + k));
                chk($sformatf("ovl_ch%0d", k), 32'(log_b_ch[k]), 32'(k % 3));
                chk($sformatf("ovl_cyc%0d", k), 32'(log_b_cyc[k] - log_b_cyc[0]), 32'(k));
            end
        end

        // Mid-operation reset: bring A to sel=1, burst_cnt=2 with a word held
        a_in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_in_data = 16'(16'h100 + k);
            tick();
        end
        a_in_valid = 1'b0; a_out_ready = 2'b00;
        chk("mid_pre_sel", 32'(a_sel), 32'd1);
        chk("mid_pre_burst", 32'(a_burst), 32'd2);
        chk("mid_pre_valid", 32'(a_out_valid), 32'h2);
        reset = 1'b1; a_out_ready = 2'b11; a_in_valid = 1'b1; a_in_data = 16'hDEAD;
        tick();
        reset = 1'b0; a_in_valid = 1'b0;
        chk("mid_valid", 32'(a_out_valid), 32'd0);
        chk("mid_sel", 32'(a_sel), 32'd0);
        chk("mid_burst", 32'(a_burst), 32'd0);
        chk("mid_data", 32'(a_out_data), 32'd0);
        a_in_data = 16'h5555; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk("mid_next_valid", 32'(a_out_valid), 32'h1);
        tick();

        // Stall on channel 0 with 0x0F0F pending
        log_a_data.delete(); log_a_ch.delete(); log_a_cyc.delete();
        a_out_ready = 2'b10;
        a_in_data = 16'h0F0F; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        if (SKIP) begin
            for (int k = 0; k < STALL - 1; k++) tick();
            chk("skip_before", 32'(a_out_valid), 32'h1);
            tick();
            chk("skip_valid", 32'(a_out_valid), 32'h2);
            chk("skip_data", 32'(a_out_data), 32'h0F0F);
            chk("skip_sel", 32'(a_sel), 32'd1);
            chk("skip_burst", 32'(a_burst), 32'd0);
            tick();
            chk("skip_log", 32'(log_a_data.size()), 32'd1);
            if (log_a_data.size() == 1) chk("skip_log_ch", 32'(log_a_ch[0]), 32'd1);
        end else begin
            for (int k = 0; k < 20; k++) begin
                chk("noskip_valid", 32'(a_out_valid), 32'h1);
                tick();
            end
            a_out_ready = 2'b11;
            tick();
            chk("noskip_log", 32'(log_a_data.size()), 32'd1);
            if (log_a_data.size() == 1) chk("noskip_log_ch", 32'(log_a_ch[0]), 32'd0);
        end
        a_out_ready = 2'b11;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
